reg_bank_port_arbiter: RTL

//   Shares the single access port of the boosted register bank among N_REQ requesters.

---
 rtl/reg_bank_port_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/reg_bank_port_arbiter.sv
// Round-robin arbiter sharing the single register-bank port among N_REQ requesters.
// One operation in flight: IDLE accepts, ISSUE strobes the bank, RESP returns read data.
module reg_bank_port_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clock_signal,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      bank_en,
  output logic                      bank_we,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic [DATA_W-1:0]         bank_wdata,
  input  logic [DATA_W-1:0]         bank_rdata
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   last_grant, grant_idx, winner;
  logic               found, accept;
  logic               we_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  wdata_p1;
  logic [DATA_W-1:0]  rdata_hold;

  // Search starts just after the last grant so every requester gets a turn.
  always_comb begin : arb
    logic [IDX_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign accept = (state == IDLE) && found && !reset;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = ISSUE;
      ISSUE:   state_next = we_p1 ? IDLE : RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_signal) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      grant_idx  <= '0;
      rdata_hold <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        grant_idx  <= winner;
        last_grant <= winner;
      end
      if (state == RESP) rdata_hold <= bank_rdata;
    end
  end

  // p1: winner's request captured at the accept edge
  always_ff @(posedge clock_signal) begin
    if (accept) begin
      we_p1    <= req_we[winner];
      addr_p1  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
      wdata_p1 <= req_wdata[int'(winner)*DATA_W +: DATA_W];
    end
  end

  // Reset suppresses responses of an interrupted op, but an already-driven bank strobe stands.
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_rdata  = rdata_hold;
    bank_en    = 1'b0;
    bank_we    = 1'b0;
    bank_addr  = '0;
    bank_wdata = '0;
    if (accept) req_ready[winner] = 1'b1;
    if (state == ISSUE) begin
      bank_en    = 1'b1;
      bank_we    = we_p1;
      bank_addr  = addr_p1;
      bank_wdata = wdata_p1;
      if (we_p1 && !reset) rsp_valid[grant_idx] = 1'b1;
    end
    if (state == RESP && !reset) begin
      rsp_valid[grant_idx] = 1'b1;
      rsp_rdata            = bank_rdata;
    end
  end

endmodule
